// File: rtl/frame_serializer.sv
// Serializes parallel words onto H one bit per symbol period, MSB first, aligned to a free-running symbol counter.
// Optional even-parity trailer symbol when FRAME_SERIALIZER_PARITY_EN is defined.
module frame_serializer #(
  parameter int   DATA_W     = 8,
  parameter int   SYM_LEN    = 11,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              H,
  output logic              sym_tick,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam int NSYM = DATA_W + 1;
`else
  localparam int NSYM = DATA_W;
`endif
  localparam int IDX_W = $clog2(NSYM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSYM - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] held_q;
  logic              held_vld;
  logic [DATA_W-1:0] load_src;
  logic              last_sym;
  logic              accept;
`ifdef FRAME_SERIALIZER_PARITY_EN
  logic              par_q;

  function automatic logic even_par(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  assign sym_tick   = (count == CNT_LAST);
  assign last_sym   = (bit_idx == IDX_LAST);
  assign busy       = (state != S_IDLE);
  assign data_ready = rst_n && ((state == S_IDLE) ||
                                (state == S_SHIFT && last_sym && !held_vld));
  assign accept     = data_valid && data_ready;

  // A word accepted on the final tick itself bypasses the holding register.
  always_comb begin
    load_src = data_in;
    if (state == S_WAIT || (state == S_SHIFT && held_vld))
      load_src = held_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count <= '0;
    else if (sym_tick) count <= '0;
    else               count <= count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      H          <= IDLE_LEVEL;
      frame_done <= 1'b0;
      bit_idx    <= '0;
      shift_q    <= '0;
      held_q     <= '0;
      held_vld   <= 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (sym_tick) begin
              shift_q <= load_src;
              H       <= load_src[DATA_W-1];
              bit_idx <= '0;
`ifdef FRAME_SERIALIZER_PARITY_EN
              par_q   <= even_par(load_src);
`endif
              state   <= S_SHIFT;
            end else begin
              held_q <= data_in;
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (sym_tick) begin
            shift_q <= load_src;
            H       <= load_src[DATA_W-1];
            bit_idx <= '0;
`ifdef FRAME_SERIALIZER_PARITY_EN
            par_q   <= even_par(load_src);
`endif
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (sym_tick) begin
            if (last_sym) begin
              frame_done <= 1'b1;
              if (held_vld || accept) begin
                shift_q  <= load_src;
                H        <= load_src[DATA_W-1];
                bit_idx  <= '0;
`ifdef FRAME_SERIALIZER_PARITY_EN
                par_q    <= even_par(load_src);
`endif
                held_vld <= 1'b0;
              end else begin
                H     <= IDLE_LEVEL;
                state <= S_IDLE;
              end
            end else begin
              // Rotate so the next bit is always at DATA_W-2 relative to the current MSB.
              shift_q <= {shift_q[DATA_W-2:0], shift_q[DATA_W-1]};
              bit_idx <= bit_idx + 1'b1;
`ifdef FRAME_SERIALIZER_PARITY_EN
              if (bit_idx == IDX_W'(DATA_W - 1)) H <= par_q;
              else                               H <= shift_q[DATA_W-2];
`else
              H <= shift_q[DATA_W-2];
`endif
            end
          end else if (accept) begin
            held_q   <= data_in;
            held_vld <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Upstream feeder for the square-wave symbol generator. Accepts parallel data words over a valid/ready handshake and drives them out one bit per symbol period on the generator's `H` level input, MSB first. A free-running symbol counter provides the symbol-boundary strobe, so `H` changes only at symbol edges. The downstream generator therefore sees one stable level for each full symbol.

## Interface
- `DATA_W`, 8: width of the data word, which is also the number of data symbols per frame (≥2).
- `SYM_LEN`, 11: clock cycles per symbol (≥2); matches the generator's period.
- `IDLE_LEVEL`, 1'b0: value driven on `H` when no frame is active.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in DATA_W: word to transmit; sampled on accept.
- `data_valid` in 1: upstream offers `data_in`.
- `data_ready` out 1: block can accept a word this cycle.
- `H` out 1: serialized bit level to the generator (registered).
- `sym_tick` out 1: high for one cycle in the last cycle of every symbol (`count == SYM_LEN-1`).
- `busy` out 1: a frame is pending or being transmitted.
- `frame_done` out 1: one-cycle pulse when a frame's final symbol has ended (registered).

## Operation
- Symbol counter `count` (width `$clog2(SYM_LEN)`) runs freely 0..SYM_LEN-1 and wraps to 0. It runs in every state and is cleared only by reset.
- Accept occurs on a rising edge where `data_valid && data_ready`.
- States:
  - IDLE: `data_ready`=1 and `H`=IDLE_LEVEL.
    - Accept with `sym_tick`=1: load the shift register and go to SHIFT.
    - Accept with `sym_tick`=0: latch the word and go to WAIT.
  - WAIT: `data_ready`=0 and `H`=IDLE_LEVEL. On `sym_tick`, load the shift register and go to SHIFT.
  - SHIFT: `H` = current bit, MSB first. On each `sym_tick`, advance the bit index.
- `data_ready`=1 in SHIFT only during the final symbol of the frame, and only while no word is already held.
  - A word accepted there is held.
  - At the final `sym_tick`, the held word loads and transmission continues with no idle symbol between frames.
- At the final `sym_tick` with no held word: go to IDLE, and `H` returns to IDLE_LEVEL on the same edge.
- `frame_done` pulses on every frame completion, including back-to-back frames.
- `busy` = (state != IDLE).
- `data_in` changes while not accepting are ignored.

## Timing
- Reset values, held while `rst_n`=0 and on the first cycle after release:
  - `count`=0, state IDLE, `H`=IDLE_LEVEL.
  - `sym_tick`=0, `busy`=0, `frame_done`=0.
  - `data_ready`=0 while `rst_n`=0, then 1 from the first cycle after release.
- Accept-to-first-bit latency is 1..SYM_LEN cycles. It is 1 cycle when the accept coincides with `sym_tick`.
- Each bit is held on `H` for exactly SYM_LEN cycles.
- `H` updates on the same edge at which `count` goes from SYM_LEN-1 to 0.
- `frame_done` is high in the cycle after the final `sym_tick`, when `count`=0.
- Reset asserted mid-frame: clear immediately and asynchronously.
  - `H`=IDLE_LEVEL.
  - The shift word and any held word are discarded.
  - No `frame_done` pulse is generated.

## Configuration
- `FRAME_SERIALIZER_PARITY_EN` defined: each frame has DATA_W+1 symbols.
  - The extra final symbol carries even parity, `^word`.
  - The `data_ready` window and `frame_done` move to the parity symbol.
- Macro undefined: each frame has exactly DATA_W symbols, and no parity logic is present.

## Test plan
All scenarios use DATA_W=8, SYM_LEN=11, IDLE_LEVEL=0.

- Reset release, no traffic:
  - `H`=0, `data_ready`=1, `busy`=0.
  - `sym_tick` pulses every 11 cycles, first at cycle 10 after release.
- Send 0xA5, accepted at `count`=3:
  - `H` stays 0 for 8 more cycles.
  - `H` then follows 1,0,1,0,0,1,0,1, each for 11 cycles (88 total).
  - `frame_done` pulses once at the first `count`=0 afterwards.
- Send 0x80, accepted on a `sym_tick` cycle:
  - `H`=1 on the next cycle for 11 cycles, then 0 for 77 cycles.
  - `H` returns to idle 0.
- Back-to-back 0xFF then 0x00, with the second word offered during the 8th symbol:
  - `H` is 1 for 88 cycles, then 0 for 88 cycles, with no idle gap.
  - `frame_done` pulses twice, 88 cycles apart.
  - `data_ready`=0 after the second accept.
- Reset pulsed during bit 4 of 0xFF:
  - `H`=0 and `busy`=0 immediately.
  - No `frame_done` pulse.
  - After release, a new 0x0F transmits correctly.
- With `FRAME_SERIALIZER_PARITY_EN` defined:
  - 0x07 gives a 9th symbol `H`=1.
  - 0x03 gives a 9th symbol `H`=0.
  - Each frame lasts 99 cycles.
